e203_icb_stub_slv: RTL and testbench

E203_ICB_STUB_SLV -- requirements
Module: e203_icb_stub_slv

---
 rtl/e203_icb_stub_slv_pkg.sv | 27 ++
 rtl/e203_icb_stub_rspq.sv | 56 +++++
 rtl/e203_icb_stub_slv.sv | 148 ++++++++++++++
 tb/tb_e203_icb_stub_slv.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_icb_stub_slv_pkg.sv
// Shared ICB widths, response payload type and byte-merge helper for the ICB stub slave.
package e203_icb_stub_slv_pkg;

    localparam int unsigned ICB_DW = 32;
    localparam int unsigned ICB_MW = 4;

    typedef struct packed {
        logic              err;
        logic [ICB_DW-1:0] rdata;
    } icb_rsp_t;

    localparam int unsigned RSP_W = $bits(icb_rsp_t);

    function automatic logic [ICB_DW-1:0] merge_bytes(
        input logic [ICB_DW-1:0] old_word,
        input logic [ICB_DW-1:0] new_word,
        input logic [ICB_MW-1:0] mask
    );
        logic [ICB_DW-1:0] res;
        res = old_word;
        for (int b = 0; b < int'(ICB_MW); b++) begin
            if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/e203_icb_stub_rspq.sv
// Synchronous response FIFO; accepts a push while full when a pop happens in the same cycle.
module e203_icb_stub_rspq
    import e203_icb_stub_slv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  icb_rsp_t      wdata,
    input  logic          pop,
    output icb_rsp_t      rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    icb_rsp_t        mem [DEPTH];
    logic [PW-1:0]   wp;
    logic [PW-1:0]   rp;
    logic [CW-1:0]   cnt;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= wdata;
                wp      <= nxt(wp);
            end
            if (do_pop) rp <= nxt(rp);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    assign rdata = mem[rp];
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/e203_icb_stub_slv.sv
// ICB slave stub: scratch RAM window, error responses outside it, fixed-latency in-order responses.
module e203_icb_stub_slv
    import e203_icb_stub_slv_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned OUTS_DEPTH = 2,
    parameter int unsigned RSP_LAT    = 1,
    parameter int unsigned MEM_WORDS  = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icb_cmd_valid,
    output logic              icb_cmd_ready,
    input  logic [AW-1:0]     icb_cmd_addr,
    input  logic              icb_cmd_read,
    input  logic [ICB_DW-1:0] icb_cmd_wdata,
    input  logic [ICB_MW-1:0] icb_cmd_wmask,
    output logic              icb_rsp_valid,
    input  logic              icb_rsp_ready,
    output logic              icb_rsp_err,
    output logic [ICB_DW-1:0] icb_rsp_rdata,
    output logic [15:0]       err_cnt
);

    localparam int unsigned CW   = $clog2(OUTS_DEPTH + 1);
    localparam int unsigned IW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);

    logic              en;
    logic              acc;
    logic              q_pop;
    logic              q_push;
    logic              q_full;
    logic              q_empty;
    logic              in_win;
    logic              byp;
    logic [CW-1:0]     q_cnt;
    logic [CW-1:0]     dl_cnt;
    logic [AW-1:0]     word_addr;
    logic [AW-1:0]     off;
    logic [IW-1:0]     idx;
    logic [ICB_DW-1:0] rd_word;
    icb_rsp_t          new_rsp;
    icb_rsp_t          q_wdata;
    icb_rsp_t          q_rdata;
    icb_rsp_t          rsp_out;
    logic              unused;

    // Ready is held low through reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) en <= 1'b0;
        else        en <= 1'b1;
    end

    // A pop from the queue frees its slot in the same cycle.
    assign q_pop         = icb_rsp_ready && !q_empty;
    assign icb_cmd_ready = en && (((dl_cnt + q_cnt) < CW'(OUTS_DEPTH)) || q_pop);
    assign acc           = icb_cmd_valid && icb_cmd_ready;

    assign word_addr = {icb_cmd_addr[AW-1:2], 2'b00};
    assign off       = word_addr - BASE;
    assign in_win    = (MEM_WORDS != 0) && (word_addr >= BASE) && (off[AW-1:2] < (AW-2)'(MEM_WORDS));
    assign idx       = off[IW+1:2];
    assign unused    = ^{icb_cmd_addr[1:0], off[1:0]};

    if (MEM_WORDS > 0) begin : g_mem
        logic [ICB_DW-1:0] mem [MEM_WORDS];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= '0;
            end else if (acc && !icb_cmd_read && in_win) begin
                mem[idx] <= merge_bytes(mem[idx], icb_cmd_wdata, icb_cmd_wmask);
            end
        end

        assign rd_word = mem[idx];
    end else begin : g_nomem
        assign rd_word = '0;
    end

    assign new_rsp.err   = !in_win;
    assign new_rsp.rdata = (icb_cmd_read && in_win) ? rd_word : '0;

    if (RSP_LAT == 0) begin : g_lat0
        // Zero latency: an empty queue is bypassed and the response is shown in the accept cycle.
        assign byp     = q_empty && acc;
        assign q_push  = acc && !(byp && icb_rsp_ready);
        assign q_wdata = new_rsp;
        assign dl_cnt  = '0;
    end else begin : g_dl
        logic [RSP_LAT-1:0] dl_vld;
        icb_rsp_t           dl_data [RSP_LAT];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dl_vld <= '0;
                for (int i = 0; i < int'(RSP_LAT); i++) dl_data[i] <= '0;
            end else begin
                dl_vld[0]  <= acc;
                dl_data[0] <= new_rsp;
                for (int i = 1; i < int'(RSP_LAT); i++) begin
                    dl_vld[i]  <= dl_vld[i-1];
                    dl_data[i] <= dl_data[i-1];
                end
            end
        end

        always_comb begin
            dl_cnt = '0;
            for (int i = 0; i < int'(RSP_LAT); i++) dl_cnt = dl_cnt + CW'(dl_vld[i]);
        end

        assign byp     = 1'b0;
        assign q_push  = dl_vld[RSP_LAT-1];
        assign q_wdata = dl_data[RSP_LAT-1];
    end

    e203_icb_stub_rspq #(
        .DEPTH (OUTS_DEPTH)
    ) u_rspq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (q_push),
        .wdata (q_wdata),
        .pop   (q_pop),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty),
        .count (q_cnt)
    );

    assign rsp_out       = !q_empty ? q_rdata : (byp ? new_rsp : '0);
    assign icb_rsp_valid = !q_empty || byp;
    assign icb_rsp_err   = rsp_out.err;
    assign icb_rsp_rdata = rsp_out.rdata;

    // Saturating count of retired error responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (icb_rsp_valid && icb_rsp_ready && icb_rsp_err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_e203_icb_stub_slv.sv
// Scoreboard bench for the ICB stub slave: default instance (RSP_LAT=1) and a zero-latency instance.
module tb_e203_icb_stub_slv;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    localparam int unsigned MEMW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_read, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] cmd_addr, cmd_wdata, rsp_rdata;
    logic [3:0]  cmd_wmask;
    logic [15:0] err_cnt;

    logic        c0_cmd_valid, c0_cmd_ready, c0_cmd_read, c0_rsp_valid, c0_rsp_ready, c0_rsp_err;
    logic [31:0] c0_cmd_addr, c0_cmd_wdata, c0_rsp_rdata;
    logic [3:0]  c0_cmd_wmask;
    logic [15:0] c0_err_cnt;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        exp_q[$];
    exp_t        exp0_q[$];
    exp_t        e1, r1, e0, r0;
    logic [31:0] mdl  [MEMW];
    logic [31:0] mdl0 [MEMW];
    logic        last_err;
    logic [31:0] last_rdata;
    int          retired0 = 0;

    e203_icb_stub_slv #(
        .AW(32), .OUTS_DEPTH(2), .RSP_LAT(1), .MEM_WORDS(16), .BASE_ADDR(32'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .icb_cmd_valid(cmd_valid), .icb_cmd_ready(cmd_ready), .icb_cmd_addr(cmd_addr),
        .icb_cmd_read(cmd_read), .icb_cmd_wdata(cmd_wdata), .icb_cmd_wmask(cmd_wmask),
        .icb_rsp_valid(rsp_valid), .icb_rsp_ready(rsp_ready), .icb_rsp_err(rsp_err),
        .icb_rsp_rdata(rsp_rdata), .err_cnt(err_cnt)
    );

    e203_icb_stub_slv #(
        .AW(32), .OUTS_DEPTH(2), .RSP_LAT(0), .MEM_WORDS(16), .BASE_ADDR(32'h0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .icb_cmd_valid(c0_cmd_valid), .icb_cmd_ready(c0_cmd_ready), .icb_cmd_addr(c0_cmd_addr),
        .icb_cmd_read(c0_cmd_read), .icb_cmd_wdata(c0_cmd_wdata), .icb_cmd_wmask(c0_cmd_wmask),
        .icb_rsp_valid(c0_rsp_valid), .icb_rsp_ready(c0_rsp_ready), .icb_rsp_err(c0_rsp_err),
        .icb_rsp_rdata(c0_rsp_rdata), .err_cnt(c0_err_cnt)
    );

    function automatic logic tb_in_win(input logic [31:0] a);
        return a < 32'(4 * MEMW);
    endfunction

    function automatic logic [31:0] tb_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Scoreboard for the RSP_LAT=1 instance: push on accept, pop on retire.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid && cmd_ready) begin
                if (!tb_in_win(cmd_addr)) e1 = '{err: 1'b1, rdata: 32'h0};
                else if (cmd_read)        e1 = '{err: 1'b0, rdata: mdl[cmd_addr[5:2]]};
                else begin
                    mdl[cmd_addr[5:2]] = tb_merge(mdl[cmd_addr[5:2]], cmd_wdata, cmd_wmask);
                    e1 = '{err: 1'b0, rdata: 32'h0};
                end
                exp_q.push_back(e1);
            end
            if (rsp_valid && rsp_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rsp_extra: got err=%0b rdata=%08h, required no response", rsp_err, rsp_rdata);
                end else begin
                    r1 = exp_q.pop_front();
                    if (rsp_err !== r1.err || rsp_rdata !== r1.rdata) begin
                        miscompares++;
                        $display("FAIL rsp_data: got err=%0b rdata=%08h, required err=%0b rdata=%08h",
                                 rsp_err, rsp_rdata, r1.err, r1.rdata);
                    end
                end
                last_err   = rsp_err;
                last_rdata = rsp_rdata;
            end
        end
    end

    // Scoreboard for the RSP_LAT=0 instance; push precedes pop because of same-cycle responses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (c0_cmd_valid && c0_cmd_ready) begin
                if (!tb_in_win(c0_cmd_addr)) e0 = '{err: 1'b1, rdata: 32'h0};
                else if (c0_cmd_read)        e0 = '{err: 1'b0, rdata: mdl0[c0_cmd_addr[5:2]]};
                else begin
                    mdl0[c0_cmd_addr[5:2]] = tb_merge(mdl0[c0_cmd_addr[5:2]], c0_cmd_wdata, c0_cmd_wmask);
                    e0 = '{err: 1'b0, rdata: 32'h0};
                end
                exp0_q.push_back(e0);
            end
            if (c0_rsp_valid && c0_rsp_ready) begin
                vectors++;
                retired0++;
                if (exp0_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rsp0_extra: got err=%0b rdata=%08h, required no response", c0_rsp_err, c0_rsp_rdata);
                end else begin
                    r0 = exp0_q.pop_front();
                    if (c0_rsp_err !== r0.err || c0_rsp_rdata !== r0.rdata) begin
                        miscompares++;
                        $display("FAIL rsp0_data: got err=%0b rdata=%08h, required err=%0b rdata=%08h",
                                 c0_rsp_err, c0_rsp_rdata, r0.err, r0.rdata);
                    end
                end
            end
        end
    end

    task automatic clear_models();
        for (int i = 0; i < int'(MEMW); i++) begin
            mdl[i]  = 32'h0;
            mdl0[i] = 32'h0;
        end
        exp_q.delete();
        exp0_q.delete();
    endtask

    // Holds a command until accepted; entered and left just after a rising edge.
    task automatic send(input logic rd, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
        bit done;
        done      = 1'b0;
        cmd_valid = 1'b1;
        cmd_read  = rd;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_wmask = m;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = cmd_ready;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL send_timeout: addr=%08h not accepted, required acceptance within 50 cycles", a);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d responses pending, required 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wmask = '0; rsp_ready = 1'b1;
        c0_cmd_valid = 1'b0; c0_cmd_read = 1'b0; c0_cmd_addr = '0; c0_cmd_wdata = '0; c0_cmd_wmask = '0;
        c0_rsp_ready = 1'b1;
        clear_models();
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({cmd_ready, rsp_valid, rsp_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ctrl: ready/valid/err=%b, required 000", {cmd_ready, rsp_valid, rsp_err});
        end
        vectors++;
        if (rsp_rdata !== 32'h0 || err_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_data: rdata=%08h err_cnt=%0d, required 0 and 0", rsp_rdata, err_cnt);
        end
        vectors++;
        if ({c0_cmd_ready, c0_rsp_valid} !== 2'b00 || c0_err_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_lat0: ready/valid=%b err_cnt=%0d, required 00 and 0", {c0_cmd_ready, c0_rsp_valid}, c0_err_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_before_edge: cmd_ready=%b, required 0", cmd_ready);
        end
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_edge: cmd_ready=%b, required 1", cmd_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        send(1'b0, 32'h8, 32'hDEADBEEF, 4'hF);
        wait_idle("wr");
        send(1'b1, 32'h8, 32'h0, 4'h0);
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_latency_early: rsp_valid=%b in accept cycle, required 0", rsp_valid);
        end
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL rd_latency: valid=%b err=%b rdata=%08h, required 1 0 deadbeef", rsp_valid, rsp_err, rsp_rdata);
        end
        @(posedge clk); #1;
        wait_idle("rd");
    endtask

    task automatic test_mask();
        send(1'b0, 32'h0, 32'hFFFFFFFF, 4'hF);
        send(1'b0, 32'h0, 32'h11223344, 4'b0101);
        send(1'b1, 32'h0, 32'h0, 4'h0);
        wait_idle("mask");
        vectors++;
        if (last_err !== 1'b0 || last_rdata !== 32'hFF22FF44) begin
            miscompares++;
            $display("FAIL mask_merge: err=%b rdata=%08h, required 0 ff22ff44", last_err, last_rdata);
        end
    endtask

    task automatic test_window();
        send(1'b1, 32'h40, 32'h0, 4'h0);
        wait_idle("oob_rd");
        vectors++;
        if (last_err !== 1'b1 || last_rdata !== 32'h0 || err_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL oob_read: err=%b rdata=%08h err_cnt=%0d, required 1 0 1", last_err, last_rdata, err_cnt);
        end
        send(1'b0, 32'h40, 32'h12345678, 4'hF);
        wait_idle("oob_wr");
        vectors++;
        if (err_cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL oob_write_cnt: err_cnt=%0d, required 2", err_cnt);
        end
        send(1'b1, 32'h2, 32'h0, 4'h0);
        wait_idle("unaligned");
        vectors++;
        if (last_err !== 1'b0 || last_rdata !== 32'hFF22FF44) begin
            miscompares++;
            $display("FAIL ram_unchanged: err=%b rdata=%08h, required 0 ff22ff44", last_err, last_rdata);
        end
        send(1'b1, 32'h3C, 32'h0, 4'h0);
        wait_idle("top_word");
        vectors++;
        if (last_err !== 1'b0) begin
            miscompares++;
            $display("FAIL top_word: err=%b, required 0", last_err);
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        send(1'b0, 32'h10, 32'hA5A5A5A5, 4'hF);
        send(1'b1, 32'h10, 32'h0, 4'h0);
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h44;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (cmd_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_ready: cmd_ready=%b with 2 outstanding, required 0", cmd_ready);
            end
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
                miscompares++;
                $display("FAIL bp_hold: valid=%b err=%b rdata=%08h, required 1 0 0", rsp_valid, rsp_err, rsp_rdata);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_pop_ready: cmd_ready=%b in pop cycle, required 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_idle("bp");
        vectors++;
        if (err_cnt !== 16'd3) begin
            miscompares++;
            $display("FAIL bp_err_cnt: err_cnt=%0d, required 3", err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic        rd_t [7];
        logic [31:0] a_t  [7];
        logic [31:0] d_t  [7];
        logic [3:0]  m_t  [7];
        rd_t = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        a_t  = '{32'h8, 32'h8, 32'h4, 32'h80, 32'h4, 32'h4, 32'h8};
        d_t  = '{32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 32'h1234BEEF, 32'h0, 32'h0};
        m_t  = '{4'hF, 4'h0, 4'h0, 4'h0, 4'b0011, 4'h0, 4'h0};
        retired0 = 0;
        for (int i = 0; i < 7; i++) begin
            c0_cmd_valid = 1'b1;
            c0_cmd_read  = rd_t[i];
            c0_cmd_addr  = a_t[i];
            c0_cmd_wdata = d_t[i];
            c0_cmd_wmask = m_t[i];
            @(negedge clk);
            vectors++;
            if (c0_cmd_ready !== 1'b1 || c0_rsp_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_cycle%0d: ready=%b rsp_valid=%b, required 1 1", i, c0_cmd_ready, c0_rsp_valid);
            end
            @(posedge clk); #1;
        end
        c0_cmd_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (retired0 !== 7 || c0_rsp_valid !== 1'b0 || c0_err_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL b2b_total: retired=%0d valid=%b err_cnt=%0d, required 7 0 1", retired0, c0_rsp_valid, c0_err_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        send(1'b0, 32'h8, 32'h5555AAAA, 4'hF);
        send(1'b0, 32'hC, 32'h0F0F0F0F, 4'hF);
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pending: rsp_valid=%b before reset, required 1", rsp_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        clear_models();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || err_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL mid_reset: valid=%b ready=%b err_cnt=%0d, required 0 0 0", rsp_valid, cmd_ready, err_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_stale_rsp: rsp_valid=%b after reset, required 0", rsp_valid);
            end
        end
        @(posedge clk); #1;
        last_rdata = 32'hFFFFFFFF;
        send(1'b1, 32'h8, 32'h0, 4'h0);
        wait_idle("mid_rd");
        vectors++;
        if (last_err !== 1'b0 || last_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_ram_cleared: err=%b rdata=%08h, required 0 0", last_err, last_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_mask();
        test_window();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
